// File: rtl/timer_pkg.sv
// timer_pkg: definitions shared by the timer block.
//   - timer_mode_e : per-channel mode encodings held in the MODE SFR
//   - CTRL_*       : bit offsets of TR/TF inside each channel's CTRL field
//   - ADDR_*_DEF   : default SFR addresses (match the core's SFR map)
//   - cnt_addr()   : address of a channel's low/high count byte
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_13BIT   = 2'd0,
    MODE_16BIT   = 2'd1,
    MODE_RELOAD8 = 2'd2,
    MODE_HALT    = 2'd3
  } timer_mode_e;

  // Each channel owns two adjacent CTRL bits: TR at 2c, TF at 2c+1.
  localparam int CTRL_BITS_PER_CH = 2;
  localparam int CTRL_TR_OFS      = 0;
  localparam int CTRL_TF_OFS      = 1;

  localparam logic [7:0] ADDR_CTRL_DEF = 8'h88;
  localparam logic [7:0] ADDR_MODE_DEF = 8'h89;
  localparam logic [7:0] ADDR_CNT_DEF  = 8'h8A;
  // SRC sits directly after MODE.
  localparam logic [7:0] ADDR_SRC_OFS  = 8'h01;

  // Count bytes are packed as TL0, TH0, TL1, TH1, ...
  function automatic logic [7:0] cnt_addr(input logic [7:0] base, input int ch, input logic hi);
    return base + 8'(2 * ch) + {7'd0, hi};
  endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one timer/counter channel.
//   Holds TH/TL, decodes the channel mode, performs increment / auto-reload
//   and detects the wrap (overflow). Optional external-pin event source when
//   TIMER_EXT_COUNT_EN is defined.
// Ports:
//   clock, reset_n      : clock, async active-low reset
//   tick                : machine-cycle enable
//   mode_i              : channel mode (timer_mode_e encoding)
//   run_i               : TR bit for this channel
//   ext_sel_i, t_pin_i  : (TIMER_EXT_COUNT_EN only) source select, raw pin
//   wr_tl_i, wr_th_i    : software byte write to TL / TH this cycle
//   wdata_i             : byte write data
//   tl_o, th_o          : current count bytes
//   ovf_o               : combinational wrap event (sets TF in the top)
//   ovf_pulse_o         : registered one-clock overflow pulse
module timer_channel
  import timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [1:0] mode_i,
  input  logic       run_i,
`ifdef TIMER_EXT_COUNT_EN
  input  logic       ext_sel_i,
  input  logic       t_pin_i,
`endif
  input  logic       wr_tl_i,
  input  logic       wr_th_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] tl_o,
  output logic [7:0] th_o,
  output logic       ovf_o,
  output logic       ovf_pulse_o
);

  logic [7:0]  tl_q, tl_d;
  logic [7:0]  th_q, th_d;
  logic        pulse_q;
  logic        evt;
  logic        step;
  logic        wrap;
  logic [12:0] cnt13;
  logic [15:0] cnt16;

`ifdef TIMER_EXT_COUNT_EN
  logic sync1_q, sync2_q, prev_q;
  logic fall;

  // Two-flop synchroniser; the edge-history flop only advances on tick so a
  // falling edge is seen on the next tick even if it lands between ticks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= t_pin_i;
      sync2_q <= sync1_q;
      if (tick) prev_q <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;
  assign evt  = run_i & tick & (ext_sel_i ? fall : 1'b1);
`else
  assign evt = run_i & tick;
`endif

  // A software write to either count byte takes precedence over counting.
  assign step = evt & ~wr_tl_i & ~wr_th_i;

  always_comb begin
    tl_d  = tl_q;
    th_d  = th_q;
    wrap  = 1'b0;
    cnt13 = {th_q, tl_q[4:0]} + 13'd1;
    cnt16 = {th_q, tl_q} + 16'd1;
    if (step) begin
      case (timer_mode_e'(mode_i))
        MODE_13BIT: begin
          // TL[7:5] are outside the 13-bit counter and keep their value.
          th_d = cnt13[12:5];
          tl_d = {tl_q[7:5], cnt13[4:0]};
          wrap = &{th_q, tl_q[4:0]};
        end
        MODE_16BIT: begin
          {th_d, tl_d} = cnt16;
          wrap         = &{th_q, tl_q};
        end
        MODE_RELOAD8: begin
          if (&tl_q) begin
            tl_d = th_q;
            wrap = 1'b1;
          end else begin
            tl_d = tl_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
    if (wr_tl_i) tl_d = wdata_i;
    if (wr_th_i) th_d = wdata_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tl_q    <= 8'h00;
      th_q    <= 8'h00;
      pulse_q <= 1'b0;
    end else begin
      tl_q    <= tl_d;
      th_q    <= th_d;
      pulse_q <= wrap;
    end
  end

  assign tl_o        = tl_q;
  assign th_o        = th_q;
  assign ovf_o       = wrap;
  assign ovf_pulse_o = pulse_q;

endmodule

// File: rtl/timer_unit.sv
// timer_unit: multi-channel 8051-style timer/counter SFR block.
//   Holds CTRL (TR/TF per channel), MODE (2 bits per channel) and, with
//   TIMER_EXT_COUNT_EN defined, SRC (count-source select per channel).
//   Decodes SFR byte/bit writes and provides a combinational read mux.
//   Counting itself lives in timer_channel, one instance per channel.
// Configuration macro: TIMER_EXT_COUNT_EN (adds t_pin input and SRC register).
// Ports:
//   clock, reset_n : clock, async active-low reset
//   tick           : machine-cycle enable
//   t_pin          : (TIMER_EXT_COUNT_EN only) external count pins
//   data_in, addr  : write data / SFR address (addr[2:0] = bit index on bit writes)
//   wr_en          : write strobe; wr_bit_en selects a bit write, bit_in its data
//   irq_ack        : per-channel interrupt acknowledge, clears TF
//   data_out       : read data for addr, 0 for addresses not owned here
//   tf             : TF flags
//   ovf_pulse      : one-clock overflow pulses
// With default addresses SRC (ADDR_MODE+1) coincides with channel 0's low
// count byte; SRC takes that address, so ext-count builds should place
// ADDR_CNT clear of it.
module timer_unit
  import timer_pkg::*;
#(
  parameter int         CHANNELS  = 2,
  parameter logic [7:0] ADDR_CTRL = ADDR_CTRL_DEF,
  parameter logic [7:0] ADDR_MODE = ADDR_MODE_DEF,
  parameter logic [7:0] ADDR_CNT  = ADDR_CNT_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                tick,
`ifdef TIMER_EXT_COUNT_EN
  input  logic [CHANNELS-1:0] t_pin,
`endif
  input  logic [7:0]          data_in,
  input  logic [7:0]          addr,
  input  logic                wr_en,
  input  logic                wr_bit_en,
  input  logic                bit_in,
  input  logic [CHANNELS-1:0] irq_ack,
  output logic [7:0]          data_out,
  output logic [CHANNELS-1:0] tf,
  output logic [CHANNELS-1:0] ovf_pulse
);

  localparam int CW = CTRL_BITS_PER_CH * CHANNELS;

  logic [CW-1:0]       ctrl_q, ctrl_d;
  logic [CW-1:0]       mode_q, mode_d;
  logic                byte_wr;
  logic                bit_wr;
  logic                src_hit;
  logic [CHANNELS-1:0] wr_tl, wr_th, ovf;
  logic [7:0]          tl_w [CHANNELS];
  logic [7:0]          th_w [CHANNELS];

  assign byte_wr = wr_en & ~wr_bit_en;
  // Bit writes address CTRL only; the low three address bits pick the bit.
  assign bit_wr  = wr_en & wr_bit_en & (addr[7:3] == ADDR_CTRL[7:3]);

`ifdef TIMER_EXT_COUNT_EN
  logic [CHANNELS-1:0] src_q, src_d;

  assign src_hit = (addr == ADDR_MODE + ADDR_SRC_OFS);

  always_comb begin
    src_d = src_q;
    if (byte_wr && src_hit) src_d = data_in[CHANNELS-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) src_q <= '0;
    else          src_q <= src_d;
  end
`else
  assign src_hit = 1'b0;
`endif

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      wr_tl[c] = byte_wr & ~src_hit & (addr == cnt_addr(ADDR_CNT, c, 1'b0));
      wr_th[c] = byte_wr & ~src_hit & (addr == cnt_addr(ADDR_CNT, c, 1'b1));
    end
  end

  // CTRL update order gives priority: software write, then irq_ack clear,
  // then the hardware overflow set (which must win over both).
  always_comb begin
    ctrl_d = ctrl_q;
    if (byte_wr && (addr == ADDR_CTRL)) ctrl_d = data_in[CW-1:0];
    if (bit_wr) begin
      for (int i = 0; i < CW; i++) begin
        if (addr[2:0] == 3'(i)) ctrl_d[i] = bit_in;
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (irq_ack[c]) ctrl_d[CTRL_BITS_PER_CH*c + CTRL_TF_OFS] = 1'b0;
      if (ovf[c])     ctrl_d[CTRL_BITS_PER_CH*c + CTRL_TF_OFS] = 1'b1;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (byte_wr && (addr == ADDR_MODE)) mode_d = data_in[CW-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      mode_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      mode_q <= mode_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    timer_channel u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .tick        (tick),
      .mode_i      (mode_q[CTRL_BITS_PER_CH*c +: 2]),
      .run_i       (ctrl_q[CTRL_BITS_PER_CH*c + CTRL_TR_OFS]),
`ifdef TIMER_EXT_COUNT_EN
      .ext_sel_i   (src_q[c]),
      .t_pin_i     (t_pin[c]),
`endif
      .wr_tl_i     (wr_tl[c]),
      .wr_th_i     (wr_th[c]),
      .wdata_i     (data_in),
      .tl_o        (tl_w[c]),
      .th_o        (th_w[c]),
      .ovf_o       (ovf[c]),
      .ovf_pulse_o (ovf_pulse[c])
    );
    assign tf[c] = ctrl_q[CTRL_BITS_PER_CH*c + CTRL_TF_OFS];
  end

  // Read mux; SRC is checked last so it owns its address, as on writes.
  always_comb begin
    data_out = 8'h00;
    if (addr == ADDR_CTRL) data_out = 8'(ctrl_q);
    if (addr == ADDR_MODE) data_out = 8'(mode_q);
    for (int c = 0; c < CHANNELS; c++) begin
      if (addr == cnt_addr(ADDR_CNT, c, 1'b0)) data_out = tl_w[c];
      if (addr == cnt_addr(ADDR_CNT, c, 1'b1)) data_out = th_w[c];
    end
`ifdef TIMER_EXT_COUNT_EN
    if (src_hit) data_out = 8'(src_q);
`endif
  end

endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: self-checking bench for timer_unit (2 channels).
// Directed scenarios plus a randomized phase, all compared against a
// behavioural model that tracks counts as integers.
module tb_timer_unit;

  localparam int         CH     = 2;
  localparam logic [7:0] A_CTRL = 8'h88;
  localparam logic [7:0] A_MODE = 8'h89;
`ifdef TIMER_EXT_COUNT_EN
  localparam logic [7:0] A_CNT  = 8'h8C;  // keep counts clear of SRC
`else
  localparam logic [7:0] A_CNT  = 8'h8A;
`endif
  localparam logic [7:0] A_TL0 = A_CNT;
  localparam logic [7:0] A_TH0 = A_CNT + 8'd1;
  localparam logic [7:0] A_TL1 = A_CNT + 8'd2;
  localparam logic [7:0] A_TH1 = A_CNT + 8'd3;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic [7:0]    addr = 8'h00;
  logic          wr_en = 1'b0;
  logic          wr_bit_en = 1'b0;
  logic          bit_in = 1'b0;
  logic [CH-1:0] irq_ack = '0;
  logic [CH-1:0] t_pin = '0;
  logic [7:0]    data_out;
  logic [CH-1:0] tf;
  logic [CH-1:0] ovf_pulse;

  always #5 clock = ~clock;

  timer_unit #(
    .CHANNELS  (CH),
    .ADDR_CTRL (A_CTRL),
    .ADDR_MODE (A_MODE),
    .ADDR_CNT  (A_CNT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .tick      (tick),
`ifdef TIMER_EXT_COUNT_EN
    .t_pin     (t_pin),
`endif
    .data_in   (data_in),
    .addr      (addr),
    .wr_en     (wr_en),
    .wr_bit_en (wr_bit_en),
    .bit_in    (bit_in),
    .irq_ack   (irq_ack),
    .data_out  (data_out),
    .tf        (tf),
    .ovf_pulse (ovf_pulse)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  bit         chk_model = 1'b1;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_tl[CH], m_th[CH], m_mode[CH];
  bit m_tr[CH], m_tf[CH], m_pulse[CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_tl[c] = 0; m_th[c] = 0; m_mode[c] = 0;
      m_tr[c] = 0; m_tf[c] = 0; m_pulse[c] = 0;
    end
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (a == A_CTRL) begin
      for (int c = 0; c < CH; c++) begin
        r[2*c]   = m_tr[c];
        r[2*c+1] = m_tf[c];
      end
    end else if (a == A_MODE) begin
      for (int c = 0; c < CH; c++) r[2*c +: 2] = 2'(m_mode[c]);
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (a == 8'(A_CNT + 2*c))     r = 8'(m_tl[c]);
        if (a == 8'(A_CNT + 2*c + 1)) r = 8'(m_th[c]);
      end
    end
    return r;
  endfunction

  task automatic model_step(input bit tk, input bit we, input bit wb, input logic [7:0] a,
                            input logic [7:0] d, input bit b, input logic [CH-1:0] ack);
    bit ovf[CH];
    bit own_wr;
    int v;
    int idx;
    for (int c = 0; c < CH; c++) begin
      ovf[c] = 0;
      own_wr = we && !wb && (a == 8'(A_CNT + 2*c) || a == 8'(A_CNT + 2*c + 1));
      if (tk && m_tr[c] && !own_wr) begin
        case (m_mode[c])
          0: begin
            v = m_th[c] * 32 + (m_tl[c] % 32) + 1;
            if (v == 8192) begin v = 0; ovf[c] = 1; end
            m_th[c] = v / 32;
            m_tl[c] = (m_tl[c] / 32) * 32 + (v % 32);
          end
          1: begin
            v = m_th[c] * 256 + m_tl[c] + 1;
            if (v == 65536) begin v = 0; ovf[c] = 1; end
            m_th[c] = v / 256;
            m_tl[c] = v % 256;
          end
          2: begin
            if (m_tl[c] == 255) begin m_tl[c] = m_th[c]; ovf[c] = 1; end
            else m_tl[c] = m_tl[c] + 1;
          end
          default: ;
        endcase
      end
    end
    if (we && !wb) begin
      for (int c = 0; c < CH; c++) begin
        if (a == A_CTRL) begin m_tr[c] = d[2*c]; m_tf[c] = d[2*c+1]; end
        if (a == A_MODE) m_mode[c] = int'(d[2*c +: 2]);
        if (a == 8'(A_CNT + 2*c))     m_tl[c] = int'(d);
        if (a == 8'(A_CNT + 2*c + 1)) m_th[c] = int'(d);
      end
    end
    if (we && wb && ((a >> 3) == (A_CTRL >> 3))) begin
      idx = int'(a % 8);
      if (idx < 2*CH) begin
        if (idx % 2 == 1) m_tf[idx/2] = b;
        else              m_tr[idx/2] = b;
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (ack[c]) m_tf[c] = 0;
      if (ovf[c]) m_tf[c] = 1;
      m_pulse[c] = ovf[c];
    end
  endtask

  function automatic logic [CH-1:0] m_tf_vec();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m_tf[c];
    return r;
  endfunction

  function automatic logic [CH-1:0] m_pulse_vec();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m_pulse[c];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle, entered and left at a negedge. data_out is checked
  // before the edge (old state), tf/ovf_pulse after it.
  task automatic cyc(input bit tk, input bit we, input bit wb, input logic [7:0] a,
                     input logic [7:0] d, input bit b, input logic [CH-1:0] ack);
    tick = tk; wr_en = we; wr_bit_en = wb; addr = a; data_in = d; bit_in = b; irq_ack = ack;
    #1;
    if (chk_model) check_eq($sformatf("rd_%02h", a), data_out, m_read(a));
    model_step(tk, we, wb, a, d, b, ack);
    @(posedge clock);
    @(negedge clock);
    if (chk_model) begin
      check_eq("tf", tf, m_tf_vec());
      check_eq("ovf_pulse", ovf_pulse, m_pulse_vec());
    end
    tick = 0; wr_en = 0; wr_bit_en = 0; irq_ack = '0;
  endtask

  task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
    cyc(0, 1, 0, a, d, 0, '0);
  endtask

  task automatic wr_bit(input int idx, input bit b);
    cyc(0, 1, 1, A_CTRL | 8'(idx), 8'h00, b, '0);
  endtask

  task automatic do_tick();
    cyc(1, 0, 0, A_CTRL, 8'h00, 0, '0);
  endtask

  task automatic rd_const(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check_eq(tag, data_out, exp);
  endtask

  task automatic rd_all(input string tag);
    for (int a = 0; a < 256; a++) exp_q.push_back(m_read(8'(a)));
    for (int a = 0; a < 256; a++) begin
      addr = 8'(a);
      #1;
      check_eq($sformatf("%s_%02h", tag, a), data_out, exp_q.pop_front());
    end
    @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  int          npulse;
  int          kind;
  logic [7:0]  ra, rd;

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset state
    check_eq("rst_tf", tf, '0);
    check_eq("rst_pulse", ovf_pulse, '0);
    rd_all("rst");

    // Channel 0, 16-bit, FFFE -> FFFF -> 0000 with overflow
    wr_byte(A_MODE, 8'h01);
    wr_byte(A_TL0, 8'hFE);
    wr_byte(A_TH0, 8'hFF);
    wr_bit(0, 1'b1);
    do_tick();
    rd_const("m1_tl_ff", A_TL0, 8'hFF);
    rd_const("m1_th_ff", A_TH0, 8'hFF);
    check_eq("m1_no_pulse", ovf_pulse[0], 1'b0);
    do_tick();
    rd_const("m1_tl_00", A_TL0, 8'h00);
    rd_const("m1_th_00", A_TH0, 8'h00);
    check_eq("m1_tf0", tf[0], 1'b1);
    check_eq("m1_pulse", ovf_pulse[0], 1'b1);
    cyc(0, 0, 0, A_CTRL, 8'h00, 0, '0);
    check_eq("m1_pulse_one_clk", ovf_pulse[0], 1'b0);

    // Channel 1, 8-bit auto-reload
    wr_bit(0, 1'b0);
    cyc(0, 0, 0, A_CTRL, 8'h00, 0, 2'b01);
    check_eq("ack_clear", tf[0], 1'b0);
    wr_byte(A_MODE, 8'h09);
    wr_byte(A_TH1, 8'hF0);
    wr_byte(A_TL1, 8'hFE);
    wr_bit(2, 1'b1);
    npulse = 0;
    do_tick(); npulse += int'(ovf_pulse[1]);
    rd_const("m2_tl_ff", A_TL1, 8'hFF);
    do_tick(); npulse += int'(ovf_pulse[1]);
    rd_const("m2_tl_f0", A_TL1, 8'hF0);
    do_tick(); npulse += int'(ovf_pulse[1]);
    rd_const("m2_tl_f1", A_TL1, 8'hF1);
    rd_const("m2_th_kept", A_TH1, 8'hF0);
    check_eq("m2_npulse", npulse, 1);
    check_eq("m2_tf1", tf[1], 1'b1);

    // Channel 0, 13-bit wrap; TL[7:5] preserved
    wr_bit(2, 1'b0);
    cyc(0, 0, 0, A_CTRL, 8'h00, 0, 2'b10);
    wr_byte(A_MODE, 8'h08);
    wr_byte(A_TL0, 8'hBF);
    wr_byte(A_TH0, 8'hFF);
    wr_bit(0, 1'b1);
    do_tick();
    rd_const("m0_th", A_TH0, 8'h00);
    rd_const("m0_tl", A_TL0, 8'hA0);
    check_eq("m0_tf0", tf[0], 1'b1);

    // Overflow coincides with irq_ack and a software clear of TF0
    wr_byte(A_TL0, 8'hBF);
    wr_byte(A_TH0, 8'hFF);
    cyc(1, 1, 1, A_CTRL | 8'd1, 8'h00, 1'b0, 2'b01);
    check_eq("set_wins", tf[0], 1'b1);
    cyc(0, 0, 0, A_CTRL, 8'h00, 0, 2'b01);
    check_eq("ack_next", tf[0], 1'b0);

    // Count write in the same cycle as a tick: write wins
    cyc(1, 1, 0, A_TL0, 8'h05, 0, '0);
    rd_const("wr_wins", A_TL0, 8'h05);
    do_tick();
    rd_const("after_wr", A_TL0, 8'h06);

    // Mode change mid-count keeps TH/TL
    wr_byte(A_MODE, 8'h09);
    rd_const("mode_chg_tl", A_TL0, 8'h06);
    rd_const("mode_chg_th", A_TH0, 8'h00);
    @(negedge clock);

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      kind = int'($urandom_range(0, 9));
      rd   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hF0, 8'hFF)) : 8'($urandom);
      case (kind)
        0, 1: cyc($urandom_range(0, 1), 1, 0, A_CTRL, 8'($urandom), 0, 2'($urandom_range(0, 3)));
        2:    cyc($urandom_range(0, 1), 1, 0, A_MODE, 8'($urandom), 0, '0);
        3, 4: cyc($urandom_range(0, 1), 1, 0, 8'(A_CNT + $urandom_range(0, 3)), rd, 0, '0);
        5:    cyc($urandom_range(0, 1), 1, 1, A_CTRL | 8'($urandom_range(0, 7)), 8'h00,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
        6:    cyc($urandom_range(0, 1), 1, 0, 8'($urandom_range(0, 127)), 8'($urandom), 0, '0);
        default: begin
          ra = 8'($urandom_range(8'h80, 8'h9F));
          cyc($urandom_range(0, 1), 0, 0, ra, 8'($urandom), 0,
              ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
        end
      endcase
    end

    // Asynchronous reset mid-count
    wr_byte(A_MODE, 8'h01);
    wr_byte(A_TL0, 8'h55);
    wr_byte(A_CTRL, 8'h0B);
    do_tick();
    do_tick();
    addr = A_TL0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_tl0", data_out, 8'h00);
    check_eq("arst_tf", tf, '0);
    check_eq("arst_pulse", ovf_pulse, '0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) do_tick();
    rd_const("no_resume", A_TL0, 8'h00);
    rd_all("post_rst");

`ifdef TIMER_EXT_COUNT_EN
    // External counting on channel 0 (model does not cover pin events)
    chk_model = 1'b0;
    wr_byte(A_MODE + 8'h01, 8'h01);
    rd_const("src_rd", A_MODE + 8'h01, 8'h01);
    wr_byte(A_MODE, 8'h01);
    wr_bit(0, 1'b1);
    t_pin[0] = 1'b1;
    repeat (8) do_tick();
    rd_const("ext_rise_only", A_TL0, 8'h00);
    for (int e = 0; e < 3; e++) begin
      t_pin[0] = 1'b0;
      repeat (6) do_tick();
      t_pin[0] = 1'b1;
      repeat (6) do_tick();
    end
    rd_const("ext_cnt3", A_TL0, 8'h03);
    rd_const("ext_th", A_TH0, 8'h00);
    repeat (20) do_tick();
    rd_const("ext_ticks_only", A_TL0, 8'h03);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
